i2s_rx: RTL

I2S_RX -- requirements
Module: i2s_rx

---
 rtl/audio_pkg.sv | 12 +
 rtl/sync_2ff.sv | 29 ++
 rtl/i2s_rx.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/audio_pkg.sv
// Shared constants and channel encoding for the audio capture blocks.
package audio_pkg;

    localparam int SAMPLE_W_DEF = 24;
    localparam int SLOT_W_DEF   = 32;

    typedef enum logic {
        LEFT  = 1'b0,
        RIGHT = 1'b1
    } chan_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/i2s_rx.sv
// I2S receiver: oversamples bclk/lrclk/sdata in the clk domain and emits L/R frames with valid/ready.
// Optional peak-magnitude tracking is built when I2S_RX_PEAK_EN is defined.
module i2s_rx
    import audio_pkg::*;
#(
    parameter int SAMPLE_W = SAMPLE_W_DEF,
    parameter int SLOT_W   = SLOT_W_DEF
) (
    input  logic                clk,
    input  logic                cpu_resetn,
    input  logic                bclk,
    input  logic                lrclk,
    input  logic                sdata,
    output logic [SAMPLE_W-1:0] sample_l,
    output logic [SAMPLE_W-1:0] sample_r,
    output logic                valid,
    input  logic                ready,
    input  logic                stat_clr,
    output logic                overrun,
    output logic                frame_err,
    output logic [SAMPLE_W-2:0] peak_l,
    output logic [SAMPLE_W-2:0] peak_r
);

    localparam int CNT_W = $clog2(SLOT_W);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SLOT_W - 1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(SAMPLE_W);

    logic bclk_s, lrclk_s, sdata_s;

    sync_2ff u_sync_bclk  (.clk(clk), .rst_n(cpu_resetn), .d(bclk),  .q(bclk_s));
    sync_2ff u_sync_lrclk (.clk(clk), .rst_n(cpu_resetn), .d(lrclk), .q(lrclk_s));
    sync_2ff u_sync_sdata (.clk(clk), .rst_n(cpu_resetn), .d(sdata), .q(sdata_s));

    logic                bclk_prev_q, bclk_prev_d;
    logic                seen_q, seen_d;
    logic                locked_q, locked_d;
    logic                lr_prev_q, lr_prev_d;
    chan_e               chan_q, chan_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [SAMPLE_W-1:0] shreg_q, shreg_d;
    logic                done_q, done_d;
    logic [SAMPLE_W-1:0] left_hold_q, left_hold_d;
    logic                left_ok_q, left_ok_d;
    logic [SAMPLE_W-1:0] sample_l_q, sample_l_d;
    logic [SAMPLE_W-1:0] sample_r_q, sample_r_d;
    logic                valid_q, valid_d;
    logic                overrun_q, overrun_d;
    logic                frame_err_q, frame_err_d;
    logic                rise, frame_form, err_set, ovr_set;

    always_comb begin
        bclk_prev_d = bclk_s;
        seen_d      = seen_q;
        locked_d    = locked_q;
        lr_prev_d   = lr_prev_q;
        chan_d      = chan_q;
        cnt_d       = cnt_q;
        shreg_d     = shreg_q;
        done_d      = done_q;
        left_hold_d = left_hold_q;
        left_ok_d   = left_ok_q;
        sample_l_d  = sample_l_q;
        sample_r_d  = sample_r_q;
        valid_d     = valid_q;
        frame_form  = 1'b0;
        err_set     = 1'b0;
        ovr_set     = 1'b0;
        rise        = bclk_s & ~bclk_prev_q;

        if (rise) begin
            lr_prev_d = lrclk_s;
            seen_d    = 1'b1;
            // An lrclk change marks a slot start; this rise carries the previous slot's last bit.
            if (seen_q && (lrclk_s != lr_prev_q)) begin
                if (locked_q && !done_q) begin
                    err_set = 1'b1;
                end
                locked_d = 1'b1;
                cnt_d    = '0;
                chan_d   = chan_e'(lrclk_s);
                done_d   = 1'b0;
            end else if (locked_q) begin
                if (cnt_q == CNT_MAX) begin
                    err_set = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_d <= CNT_DONE) begin
                        shreg_d = {shreg_q[SAMPLE_W-2:0], sdata_s};
                    end
                    if (cnt_d == CNT_DONE) begin
                        done_d = 1'b1;
                        if (chan_q == LEFT) begin
                            left_hold_d = shreg_d;
                            left_ok_d   = 1'b1;
                        end else if (left_ok_q) begin
                            frame_form = 1'b1;
                            left_ok_d  = 1'b0;
                        end
                    end
                end
            end
        end

        if (frame_form) begin
            sample_l_d = left_hold_q;
            sample_r_d = shreg_d;
            valid_d    = 1'b1;
            ovr_set    = valid_q & ~ready;
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
        end

        overrun_d   = (overrun_q & ~stat_clr) | ovr_set;
        frame_err_d = (frame_err_q & ~stat_clr) | err_set;
    end

    always_ff @(posedge clk) begin
        if (!cpu_resetn) begin
            bclk_prev_q <= 1'b0;
            seen_q      <= 1'b0;
            locked_q    <= 1'b0;
            lr_prev_q   <= 1'b0;
            chan_q      <= LEFT;
            cnt_q       <= '0;
            shreg_q     <= '0;
            done_q      <= 1'b0;
            left_hold_q <= '0;
            left_ok_q   <= 1'b0;
            sample_l_q  <= '0;
            sample_r_q  <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            bclk_prev_q <= bclk_prev_d;
            seen_q      <= seen_d;
            locked_q    <= locked_d;
            lr_prev_q   <= lr_prev_d;
            chan_q      <= chan_d;
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            done_q      <= done_d;
            left_hold_q <= left_hold_d;
            left_ok_q   <= left_ok_d;
            sample_l_q  <= sample_l_d;
            sample_r_q  <= sample_r_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign sample_l  = sample_l_q;
    assign sample_r  = sample_r_q;
    assign valid     = valid_q;
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;

`ifdef I2S_RX_PEAK_EN
    // Magnitude saturated to SAMPLE_W-1 bits; the most-negative code maps to all ones.
    function automatic logic [SAMPLE_W-2:0] mag(input logic [SAMPLE_W-1:0] s);
        logic [SAMPLE_W-1:0] neg;
        neg = -s;
        if (!s[SAMPLE_W-1])
            mag = s[SAMPLE_W-2:0];
        else if (neg[SAMPLE_W-1])
            mag = '1;
        else
            mag = neg[SAMPLE_W-2:0];
    endfunction

    logic [SAMPLE_W-2:0] peak_l_q, peak_l_d;
    logic [SAMPLE_W-2:0] peak_r_q, peak_r_d;
    logic [SAMPLE_W-2:0] mag_l, mag_r;

    always_comb begin
        peak_l_d = stat_clr ? '0 : peak_l_q;
        peak_r_d = stat_clr ? '0 : peak_r_q;
        mag_l    = mag(sample_l_d);
        mag_r    = mag(sample_r_d);
        if (frame_form) begin
            if (mag_l > peak_l_d) peak_l_d = mag_l;
            if (mag_r > peak_r_d) peak_r_d = mag_r;
        end
    end

    always_ff @(posedge clk) begin
        if (!cpu_resetn) begin
            peak_l_q <= '0;
            peak_r_q <= '0;
        end else begin
            peak_l_q <= peak_l_d;
            peak_r_q <= peak_r_d;
        end
    end

    assign peak_l = peak_l_q;
    assign peak_r = peak_r_q;
`else
    assign peak_l = '0;
    assign peak_r = '0;
`endif

endmodule
